// File: rtl/shift_pipe_pkg.sv
// shift_pipe_pkg: shared op encoding and fine-shift constants for the shifter pipeline
package shift_pipe_pkg;
  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA, SH_ROR} shift_op_t;
  localparam int FINE_W = 3;
endpackage

// File: rtl/shift_pipe_if.sv
// shift_pipe_if: valid/ready issue and writeback bundle of the shifter pipeline
interface shift_pipe_if #(parameter int WIDTH = 32, parameter int TAG_W = 5);
  import shift_pipe_pkg::*;
  localparam int SHW = $clog2(WIDTH);
  logic in_valid;
  logic in_ready;
  shift_op_t in_op;
  logic [SHW-1:0] in_shamt;
  logic [WIDTH-1:0] in_data;
  logic [TAG_W-1:0] in_tag;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  modport master(output in_valid, in_op, in_shamt, in_data, in_tag, out_ready, input in_ready, out_valid, out_data, out_tag);
  modport slave(input in_valid, in_op, in_shamt, in_data, in_tag, out_ready, output in_ready, out_valid, out_data, out_tag);
endinterface

// File: rtl/three_eight_decoder.sv
// three_eight_decoder: one-hot window select, index k for right shifts and 7-k for left
module three_eight_decoder (
  input  logic [2:0] k,
  input  logic       right,
  output logic [7:0] sel
);
  assign sel = 8'b1 << (right ? k : 3'd7 - k);
endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: two-stage SLL/SRL/SRA shifter, coarse byte shift then fine window mux; SHIFT_PIPE_ROTATE_EN adds ROR
module shift_pipe
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input logic         clk,
  input logic         reset_n,
  input logic         flush,
  shift_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  typedef struct packed {
    logic [WIDTH-1:0] data;
    shift_op_t        op;
    logic             fill;
    logic [7:0]       sel;
    logic [TAG_W-1:0] tag;
  } s1_t;
  s1_t s1, s1_nxt;
  logic s1_valid, s2_valid, s1_adv, s2_adv;
  logic [SHW-1:0] sh8;
  logic [WIDTH-1:0] sll_v, srl_v, rot_v, coarse, fine, out_data;
  logic signed [WIDTH-1:0] sra_v;
  logic [TAG_W-1:0] out_tag;
  logic [7:0] sel;
  logic [WIDTH+6:0] w;
  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_data = out_data;
  assign bus.out_tag = out_tag;
  assign sh8 = {bus.in_shamt[SHW-1:FINE_W], 3'b000};
  assign sll_v = bus.in_data << sh8;
  assign srl_v = bus.in_data >> sh8;
  assign sra_v = $signed(bus.in_data) >>> sh8;
`ifdef SHIFT_PIPE_ROTATE_EN
  assign rot_v = WIDTH'({bus.in_data, bus.in_data} >> sh8);
`else
  assign rot_v = srl_v;
`endif
  three_eight_decoder u_dec (
    .k    (bus.in_shamt[FINE_W-1:0]),
    .right(bus.in_op != SH_SLL),
    .sel  (sel)
  );
  // stage 1: coarse byte shift and stage payload
  always_comb begin
    coarse = bus.in_op == SH_SLL ? sll_v : bus.in_op == SH_SRA ? sra_v : bus.in_op == SH_SRL ? srl_v : rot_v;
    s1_nxt = '{data: coarse, op: bus.in_op, fill: bus.in_op == SH_SRA && bus.in_data[WIDTH-1], sel: sel, tag: bus.in_tag};
  end
  // stage 2: extended window, one-hot select of the WIDTH-bit slice
  always_comb begin
    w = s1.op == SH_SLL ? {s1.data, 7'b0} : {{7{s1.fill}}, s1.data};
`ifdef SHIFT_PIPE_ROTATE_EN
    if (s1.op == SH_ROR) w = {s1.data[6:0], s1.data};
`endif
    fine = '0;
    for (int j = 0; j < 8; j++) fine = fine | (s1.sel[j] ? w[j +: WIDTH] : '0);
  end
  // pipeline registers: flush drops both valids, stalled stages hold their payload
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1 <= '0;
      out_data <= '0;
      out_tag <= '0;
    end else begin
      s1_valid <= !flush && (s1_adv ? bus.in_valid : s1_valid);
      s2_valid <= !flush && (s2_adv ? s1_valid : s2_valid);
      if (s1_adv && bus.in_valid) s1 <= s1_nxt;
      if (s2_adv && s1_valid) begin
        out_data <= fine;
        out_tag <= s1.tag;
      end
    end
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed vectors with a scoreboard queue and an independent output monitor
module tb_shift_pipe;
  import shift_pipe_pkg::*;
  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] data;
  } exp_t;
  logic clk = 0;
  logic reset_n = 0;
  logic flush = 0;
  exp_t q[$];
  int passed = 0;
  int total = 0;
  int n_out = 0;
  shift_pipe_if #(.WIDTH(32), .TAG_W(5)) bus ();
  shift_pipe #(.WIDTH(32), .TAG_W(5)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (flush),
    .bus    (bus.slave)
  );
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s got=%h want=%h", name, got, want);
  endtask

  // monitor: every accepted output must match the oldest expectation
  always @(negedge clk)
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_out got=%h tag=%h", bus.out_data, bus.out_tag);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_data", bus.out_data, e.data);
        check("out_tag", 32'(bus.out_tag), 32'(e.tag));
        n_out++;
      end
    end

  task automatic send(input logic [1:0] op, input logic [4:0] sh, input logic [31:0] d, input logic [4:0] tag, input logic [31:0] e);
    int n = 0;
    logic ok;
    bus.in_valid = 1;
    bus.in_op = shift_op_t'(op);
    bus.in_shamt = sh;
    bus.in_data = d;
    bus.in_tag = tag;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    bus.in_valid = 0;
    if (ok) q.push_back('{tag: tag, data: e});
    else begin
      total++;
      $display("FAIL send_timeout tag=%0d", tag);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    logic [31:0] rot8, rot4;
    bus.in_valid = 0;
    bus.in_op = SH_SLL;
    bus.in_shamt = 0;
    bus.in_data = 0;
    bus.in_tag = 0;
    bus.out_ready = 1;
    #3;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_tag", 32'(bus.out_tag), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    // extreme shift amounts with latency probe
    send(2'b00, 5'd31, 32'h0000_0001, 5'd1, 32'h8000_0000);
    check("lat1_valid", 32'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    check("lat2_valid", 32'(bus.out_valid), 1);
    check("lat2_data", bus.out_data, 32'h8000_0000);
    send(2'b01, 5'd31, 32'h8000_0000, 5'd2, 32'h0000_0001);
    send(2'b10, 5'd31, 32'h8000_0000, 5'd3, 32'hFFFF_FFFF);
    send(2'b10, 5'd4, 32'hF000_0000, 5'd4, 32'hFF00_0000);
    send(2'b10, 5'd12, 32'h7000_0000, 5'd5, 32'h0007_0000);
    send(2'b00, 5'd0, 32'hA5A5_1234, 5'd6, 32'hA5A5_1234);
    send(2'b01, 5'd0, 32'hA5A5_1234, 5'd7, 32'hA5A5_1234);
    send(2'b10, 5'd0, 32'h8000_0001, 5'd8, 32'h8000_0001);
    send(2'b11, 5'd0, 32'h8000_0001, 5'd9, 32'h8000_0001);
`ifdef SHIFT_PIPE_ROTATE_EN
    rot8 = 32'h7812_3456;
    rot4 = 32'h8123_4567;
`else
    rot8 = 32'h0012_3456;
    rot4 = 32'h0123_4567;
`endif
    send(2'b11, 5'd8, 32'h1234_5678, 5'd10, rot8);
    send(2'b11, 5'd4, 32'h1234_5678, 5'd11, rot4);
    drain();
    // ten back-to-back ops: all ten must appear within ten cycles of the first result
    k = n_out;
    send(2'b00, 5'd4, 32'h0000_00FF, 5'd0, 32'h0000_0FF0);
    send(2'b01, 5'd8, 32'hFF00_0000, 5'd1, 32'h00FF_0000);
    send(2'b10, 5'd1, 32'h8000_0000, 5'd2, 32'hC000_0000);
    send(2'b00, 5'd16, 32'h1234_5678, 5'd3, 32'h5678_0000);
    send(2'b01, 5'd20, 32'h1234_5678, 5'd4, 32'h0000_0123);
    send(2'b10, 5'd28, 32'h8765_4321, 5'd5, 32'hFFFF_FFF8);
    send(2'b00, 5'd9, 32'hDEAD_BEEF, 5'd6, 32'h5B7D_DE00);
    send(2'b01, 5'd3, 32'hDEAD_BEEF, 5'd7, 32'h1BD5_B7DD);
    send(2'b10, 5'd3, 32'hDEAD_BEEF, 5'd8, 32'hFBD5_B7DD);
    send(2'b00, 5'd30, 32'h0000_0003, 5'd9, 32'hC000_0000);
    repeat (2) @(posedge clk);
    #3;
    check("b2b_count", 32'(n_out - k), 10);
    drain();
    // backpressure: two ops held while out_ready is low
    bus.out_ready = 0;
    send(2'b00, 5'd4, 32'h0000_0001, 5'd21, 32'h0000_0010);
    send(2'b01, 5'd4, 32'h8000_0000, 5'd22, 32'h0800_0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(bus.in_ready), 0);
      check("stall_valid", 32'(bus.out_valid), 1);
      check("stall_data", bus.out_data, 32'h0000_0010);
      check("stall_tag", 32'(bus.out_tag), 21);
    end
    @(posedge clk);
    #1 bus.out_ready = 1;
    drain();
    // asynchronous reset with both stages occupied
    bus.out_ready = 0;
    send(2'b00, 5'd1, 32'h0000_0001, 5'd12, 32'h0000_0002);
    send(2'b00, 5'd2, 32'h0000_0001, 5'd13, 32'h0000_0004);
    check("prerst_valid", 32'(bus.out_valid), 1);
    #1 reset_n = 0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 0);
    check("arst_data", bus.out_data, 0);
    check("arst_tag", 32'(bus.out_tag), 0);
    check("arst_in_ready", 32'(bus.in_ready), 1);
    q.delete();
    @(posedge clk);
    #1 reset_n = 1;
    bus.out_ready = 1;
    k = n_out;
    repeat (4) @(posedge clk);
    #1;
    check("arst_no_out", 32'(n_out - k), 0);
    // flush with both stages full and a pending input
    bus.out_ready = 0;
    send(2'b00, 5'd1, 32'h0000_0003, 5'd14, 32'h0000_0006);
    send(2'b00, 5'd2, 32'h0000_0003, 5'd15, 32'h0000_000C);
    bus.in_valid = 1;
    bus.in_data = 32'h0000_00FF;
    bus.in_tag = 5'd16;
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    bus.in_valid = 0;
    q.delete();
    check("flush_valid", 32'(bus.out_valid), 0);
    check("flush_in_ready", 32'(bus.in_ready), 1);
    // flush beats an input that would otherwise be accepted
    bus.out_ready = 1;
    bus.in_valid = 1;
    bus.in_tag = 5'd17;
    flush = 1;
    @(negedge clk);
    check("flush_ready_hi", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    flush = 0;
    bus.in_valid = 0;
    k = n_out;
    repeat (4) @(posedge clk);
    #1;
    check("flush_no_out", 32'(n_out - k), 0);
    check("flush_s1_empty", 32'(bus.out_valid), 0);
    drain();
    check("queue_empty", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end
endmodule
